// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell codes, sequencer FSM states, the
// eight winning lines and board read/write helpers for the 18-bit flat board.
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'd0;
  localparam logic [1:0] CELL_CROSS  = 2'd1;
  localparam logic [1:0] CELL_CIRCLE = 2'd2;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  // Index l holds the three cells of line l: rows, columns, main and anti diagonal.
  localparam logic [NUM_LINES-1:0][2:0][3:0] LINE_TABLE = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };

  // Out-of-range indices read as empty, so callers need no separate guard.
  function automatic logic [1:0] cell_get(input logic [17:0] board,
                                          input logic [3:0]  idx);
    cell_get = CELL_EMPTY;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (idx == 4'(k)) cell_get = board[2*k +: 2];
    end
  endfunction

  function automatic logic [17:0] cell_set(input logic [17:0] board,
                                           input logic [3:0]  idx,
                                           input logic [1:0]  val);
    cell_set = board;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (idx == 4'(k)) cell_set[2*k +: 2] = val;
    end
  endfunction

endpackage

// File: rtl/move_sequencer_win_detector.sv
// Combinational three-in-a-row detector over the flat board; reports every
// completed line and the owner of the lowest-numbered one.
module win_detector
  import tictactoe_pkg::*;
(
  input  logic [17:0] state_flat_i,
  output logic [1:0]  winner_o,
  output logic [7:0]  win_line_o
);

  always_comb begin
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    a          = CELL_EMPTY;
    b          = CELL_EMPTY;
    c          = CELL_EMPTY;
    winner_o   = CELL_EMPTY;
    win_line_o = '0;
    for (int l = 0; l < NUM_LINES; l++) begin
      a = cell_get(state_flat_i, LINE_TABLE[l][0]);
      b = cell_get(state_flat_i, LINE_TABLE[l][1]);
      c = cell_get(state_flat_i, LINE_TABLE[l][2]);
      if ((a != CELL_EMPTY) && (a == b) && (b == c)) begin
        win_line_o[l] = 1'b1;
        if (winner_o == CELL_EMPTY) winner_o = a;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Tic-tac-toe move sequencer: validates key presses, owns the board and the
// oldest-first piece queue, alternates turns and latches the game result.
module move_sequencer
  import tictactoe_pkg::*;
#(
  parameter int MAX_PIECES = 6,
  parameter int QPTR_W     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        keyValid,
  input  logic [3:0]  keyCell,
  input  logic        restart,
  output logic        moveAccept,
  output logic        moveReject,
  output logic [17:0] state_flat,
  output logic        turn,
  output logic [1:0]  winner,
  output logic [7:0]  winLine,
  output logic        gameOver,
  output logic [7:0]  moveCount
);

  localparam int CNT_W = QPTR_W + 1;

  // Handshake: keyValid is a one-cycle request with no backpressure. Every
  // request is answered exactly once on the following cycle by moveAccept or
  // moveReject (never both), except when restart is high in the same cycle,
  // in which case the request is dropped silently.

  state_e                state_q, state_d;
  logic [17:0]           board_q, board_d;
  logic                  turn_q, turn_d;
  logic [1:0]            winner_q, winner_d;
  logic [7:0]            win_line_q, win_line_d;
  logic [7:0]            move_count_q, move_count_d;
  logic                  accept_q, accept_d;
  logic                  reject_q, reject_d;
  logic [QPTR_W-1:0]     head_q, head_d;
  logic [QPTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [3:0]            q_mem_q [MAX_PIECES];

  logic                  clear_game;
  logic                  key_ok;
  logic                  queue_full;
  logic [3:0]            evict_cell;
  logic [17:0]           board_placed;
  logic [1:0]            det_winner;
  logic [7:0]            det_line;

  function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
    return (p == QPTR_W'(MAX_PIECES - 1)) ? '0 : p + QPTR_W'(1);
  endfunction

  assign clear_game   = !reset || restart;
  assign key_ok       = keyValid && (state_q == ST_PLAY) && (keyCell <= 4'd8) &&
                        (cell_get(board_q, keyCell) == CELL_EMPTY);
  assign queue_full   = (count_q == CNT_W'(MAX_PIECES));
  assign evict_cell   = q_mem_q[head_q];
  assign board_placed = cell_set(board_q, keyCell, turn_q ? CELL_CROSS : CELL_CIRCLE);

  win_detector u_win_detector (
    .state_flat_i (board_q),
    .winner_o     (det_winner),
    .win_line_o   (det_line)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (clear_game) state_q <= ST_PLAY;
    else            state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY:  if (key_ok) state_d = ST_CHECK;
      ST_CHECK: state_d = (det_winner != CELL_EMPTY) ? ST_OVER : ST_PLAY;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_PLAY;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    board_d      = board_q;
    turn_d       = turn_q;
    winner_d     = winner_q;
    win_line_d   = win_line_q;
    move_count_d = move_count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    accept_d     = 1'b0;
    reject_d     = 1'b0;
    case (state_q)
      ST_PLAY: begin
        if (key_ok) begin
          // A full queue evicts the oldest piece on the same edge as the placement.
          if (queue_full) begin
            board_d = cell_set(board_placed, evict_cell, CELL_EMPTY);
            head_d  = ptr_inc(head_q);
          end else begin
            board_d = board_placed;
            count_d = count_q + CNT_W'(1);
          end
          tail_d       = ptr_inc(tail_q);
          accept_d     = 1'b1;
          move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
        end else if (keyValid) begin
          reject_d = 1'b1;
        end
      end
      ST_CHECK: begin
        reject_d = keyValid;
        if (det_winner != CELL_EMPTY) begin
          winner_d   = det_winner;
          win_line_d = det_line;
        end else begin
          turn_d = ~turn_q;
        end
      end
      ST_OVER: reject_d = keyValid;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear_game) begin
      board_q      <= '0;
      turn_q       <= 1'b1;
      winner_q     <= CELL_EMPTY;
      win_line_q   <= '0;
      move_count_q <= '0;
      accept_q     <= 1'b0;
      reject_q     <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < MAX_PIECES; i++) q_mem_q[i] <= '0;
    end else begin
      board_q      <= board_d;
      turn_q       <= turn_d;
      winner_q     <= winner_d;
      win_line_q   <= win_line_d;
      move_count_q <= move_count_d;
      accept_q     <= accept_d;
      reject_q     <= reject_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      if (key_ok) q_mem_q[tail_q] <= keyCell;
    end
  end

  assign moveAccept = accept_q;
  assign moveReject = reject_q;
  assign state_flat = board_q;
  assign turn       = turn_q;
  assign winner     = winner_q;
  assign winLine    = win_line_q;
  assign gameOver   = (state_q == ST_OVER);
  assign moveCount  = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed vector table followed by random play
// against a queue-based game model.
module tb_move_sequencer;

  localparam int MAXP = 6;

  logic        clock;
  logic        reset;
  logic        keyValid;
  logic [3:0]  keyCell;
  logic        restart;
  logic        moveAccept;
  logic        moveReject;
  logic [17:0] state_flat;
  logic        turn;
  logic [1:0]  winner;
  logic [7:0]  winLine;
  logic        gameOver;
  logic [7:0]  moveCount;

  int tests = 0;
  int fails = 0;

  move_sequencer #(.MAX_PIECES(MAXP), .QPTR_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .keyValid   (keyValid),
    .keyCell    (keyCell),
    .restart    (restart),
    .moveAccept (moveAccept),
    .moveReject (moveReject),
    .state_flat (state_flat),
    .turn       (turn),
    .winner     (winner),
    .winLine    (winLine),
    .gameOver   (gameOver),
    .moveCount  (moveCount)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: board as an array, pieces as an ordered queue
  int  m_board [9];
  int  m_q [$];
  bit  m_turn, m_checking, m_over, m_acc, m_rej;
  int  m_winner, m_line, m_mc;
  int  lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic model_step(input logic rn, input logic rs, input logic kv, input logic [3:0] kc);
    int line, owner;
    m_acc = 0;
    m_rej = 0;
    if (!rn || rs) begin
      for (int k = 0; k < 9; k++) m_board[k] = 0;
      m_q.delete();
      m_turn = 1; m_checking = 0; m_over = 0;
      m_winner = 0; m_line = 0; m_mc = 0;
    end else if (m_over) begin
      m_rej = kv;
    end else if (m_checking) begin
      m_rej = kv;
      line = 0; owner = 0;
      for (int l = 0; l < 8; l++) begin
        if (m_board[lines[l][0]] != 0 && m_board[lines[l][0]] == m_board[lines[l][1]] &&
            m_board[lines[l][1]] == m_board[lines[l][2]]) begin
          line |= (1 << l);
          if (owner == 0) owner = m_board[lines[l][0]];
        end
      end
      if (line != 0) begin
        m_over = 1; m_winner = owner; m_line = line;
      end else begin
        m_turn = !m_turn;
      end
      m_checking = 0;
    end else if (kv) begin
      if (kc > 8) m_rej = 1;
      else if (m_board[kc] != 0) m_rej = 1;
      else begin
        m_board[kc] = m_turn ? 1 : 2;
        if (m_q.size() == MAXP) m_board[m_q.pop_front()] = 0;
        m_q.push_back(int'(kc));
        m_acc = 1;
        if (m_mc < 255) m_mc++;
        m_checking = 1;
      end
    end
  endtask

  function automatic logic [17:0] model_flat();
    logic [17:0] f;
    f = '0;
    for (int k = 0; k < 9; k++) f[2*k +: 2] = 2'(m_board[k]);
    return f;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, sample on the falling edge
  task automatic step(input logic rn, input logic rs, input logic kv, input logic [3:0] kc);
    reset    = rn;
    restart  = rs;
    keyValid = kv;
    keyCell  = kc;
    model_step(rn, rs, kv, kc);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " board"},     32'(state_flat), 32'(model_flat()));
    chk({tag, " turn"},      32'(turn),       32'(m_turn));
    chk({tag, " accept"},    32'(moveAccept), 32'(m_acc));
    chk({tag, " reject"},    32'(moveReject), 32'(m_rej));
    chk({tag, " gameOver"},  32'(gameOver),   32'(m_over));
    chk({tag, " winner"},    32'(winner),     32'(m_winner));
    chk({tag, " winLine"},   32'(winLine),    32'(m_line));
    chk({tag, " moveCount"}, 32'(moveCount),  32'(m_mc));
    chk({tag, " acc_rej_excl"}, 32'(moveAccept & moveReject), 32'd0);
  endtask

  typedef struct {
    logic        rs;
    logic        kv;
    logic [3:0]  kc;
    logic        acc;
    logic        rej;
    logic [17:0] board;
    logic        trn;
    logic        over;
    logic [1:0]  win;
    logic [7:0]  line;
    logic [7:0]  mc;
  } vec_t;

  vec_t vecs [$];

  function automatic void v(input logic rs, input logic kv, input logic [3:0] kc,
                            input logic acc, input logic rej, input logic [17:0] board,
                            input logic trn, input logic over, input logic [1:0] win,
                            input logic [7:0] line, input logic [7:0] mc);
    vec_t r;
    r.rs = rs; r.kv = kv; r.kc = kc; r.acc = acc; r.rej = rej; r.board = board;
    r.trn = trn; r.over = over; r.win = win; r.line = line; r.mc = mc;
    vecs.push_back(r);
  endfunction

  initial begin
    logic rn, rs, kv;
    logic [3:0] kc;
    reset = 1'b0; restart = 1'b0; keyValid = 1'b0; keyCell = '0;
    @(negedge clock);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    check_model("reset");

    // first move, duplicate and out-of-range cells, restart beating keyValid
    v(0,1,4, 1,0,18'h00100, 1,0,0,8'h00,1);
    v(0,0,0, 0,0,18'h00100, 0,0,0,8'h00,1);
    v(0,1,4, 0,1,18'h00100, 0,0,0,8'h00,1);
    v(0,1,9, 0,1,18'h00100, 0,0,0,8'h00,1);
    v(1,1,0, 0,0,18'h00000, 1,0,0,8'h00,0);
    // key in CHECK cycle, then cross completes the top row
    v(0,1,0, 1,0,18'h00001, 1,0,0,8'h00,1);
    v(0,1,5, 0,1,18'h00001, 0,0,0,8'h00,1);
    v(0,1,3, 1,0,18'h00081, 0,0,0,8'h00,2);
    v(0,0,0, 0,0,18'h00081, 1,0,0,8'h00,2);
    v(0,1,1, 1,0,18'h00085, 1,0,0,8'h00,3);
    v(0,0,0, 0,0,18'h00085, 0,0,0,8'h00,3);
    v(0,1,4, 1,0,18'h00285, 0,0,0,8'h00,4);
    v(0,0,0, 0,0,18'h00285, 1,0,0,8'h00,4);
    v(0,1,2, 1,0,18'h00295, 1,0,0,8'h00,5);
    v(0,0,0, 0,0,18'h00295, 1,1,1,8'h01,5);
    v(0,1,6, 0,1,18'h00295, 1,1,1,8'h01,5);
    v(1,0,0, 0,0,18'h00000, 1,0,0,8'h00,0);
    // six pieces without a line, then two evictions
    v(0,1,0, 1,0,18'h00001, 1,0,0,8'h00,1);
    v(0,0,0, 0,0,18'h00001, 0,0,0,8'h00,1);
    v(0,1,1, 1,0,18'h00009, 0,0,0,8'h00,2);
    v(0,0,0, 0,0,18'h00009, 1,0,0,8'h00,2);
    v(0,1,2, 1,0,18'h00019, 1,0,0,8'h00,3);
    v(0,0,0, 0,0,18'h00019, 0,0,0,8'h00,3);
    v(0,1,4, 1,0,18'h00219, 0,0,0,8'h00,4);
    v(0,0,0, 0,0,18'h00219, 1,0,0,8'h00,4);
    v(0,1,3, 1,0,18'h00259, 1,0,0,8'h00,5);
    v(0,0,0, 0,0,18'h00259, 0,0,0,8'h00,5);
    v(0,1,5, 1,0,18'h00A59, 0,0,0,8'h00,6);
    v(0,0,0, 0,0,18'h00A59, 1,0,0,8'h00,6);
    v(0,1,7, 1,0,18'h04A58, 1,0,0,8'h00,7);
    v(0,0,0, 0,0,18'h04A58, 0,0,0,8'h00,7);
    v(0,1,6, 1,0,18'h06A50, 0,0,0,8'h00,8);
    v(0,0,0, 0,0,18'h06A50, 1,0,0,8'h00,8);
    v(1,0,0, 0,0,18'h00000, 1,0,0,8'h00,0);

    step(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      step(1'b1, vecs[i].rs, vecs[i].kv, vecs[i].kc);
      t = $sformatf("vec%0d", i);
      chk({t, " board"},     32'(state_flat), 32'(vecs[i].board));
      chk({t, " turn"},      32'(turn),       32'(vecs[i].trn));
      chk({t, " accept"},    32'(moveAccept), 32'(vecs[i].acc));
      chk({t, " reject"},    32'(moveReject), 32'(vecs[i].rej));
      chk({t, " gameOver"},  32'(gameOver),   32'(vecs[i].over));
      chk({t, " winner"},    32'(winner),     32'(vecs[i].win));
      chk({t, " winLine"},   32'(winLine),    32'(vecs[i].line));
      chk({t, " moveCount"}, 32'(moveCount),  32'(vecs[i].mc));
    end

    // random play against the model
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      rs = ($urandom_range(0, 59) == 0);
      kv = 1'($urandom_range(0, 1));
      kc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      step(rn, rs, kv, kc);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
